serial_rx: RTL and testbench
============================

// Module: serial_rx
// PURPOSE
// - Asynchronous serial receiver (UART-style, 8N1 by default): samples a serial line
//   and reassembles frames into parallel words. Receive end of the team's serial link.
// - Frame on rx: idle high, start bit 0, DATA_BITS data bits LSB first, one stop bit 1.
// - Sits between an external pin and a parallel consumer; emits one valid pulse per good frame.
// PARAMETERS
// - DATA_BITS     8   data bits per frame (1..16)
// - CLKS_PER_BIT  16  clk cycles per bit period; integer >= 4 (baud = f_clk/CLKS_PER_BIT)
// PORTS
// - clk        in   1          system clock, rising edge
// - arst       in   1          asynchronous reset, active-high
// - rx         in   1          serial input, asynchronous to clk, idle high
// - data       out  DATA_BITS  last good received word; holds until next good frame
// - valid      out  1          1-cycle pulse: data updated with a good frame
// - frame_err  out  1          1-cycle pulse: stop bit sampled 0; data not updated
// - busy       out  1          high in any state other than IDLE
// BEHAVIOUR
// - Reset: clk is clk; reset is arst, asynchronous, active-high. While arst: state=IDLE,
//   data=0, valid=0, frame_err=0, busy=0, bit/cycle counters=0, synchronizer flops=1.
// - Reset mid-frame aborts the frame silently: no valid, no frame_err. After release, a low
//   line is treated as a new start bit (resync is the sender's problem).
// - rx passes through a 2-flop synchronizer -> rx_s; FSM uses rx_s only (2-cycle delay).
// - cnt: $clog2(CLKS_PER_BIT) bits; bitn: counts 0..DATA_BITS-1.
// - IDLE:  rx_s==0 -> START, cnt=0.
// - START: cnt++; at cnt==CLKS_PER_BIT/2-1 (mid start bit): rx_s==0 -> DATA, cnt=0, bitn=0;
//          rx_s==1 -> IDLE (glitch rejected, no pulse).
// - DATA:  cnt++; at cnt==CLKS_PER_BIT-1 (mid data bit): shift rx_s into MSB of shift reg
//          (LSB-first reassembly), cnt=0; bitn==DATA_BITS-1 -> STOP, else bitn++.
// - STOP:  cnt++; at cnt==CLKS_PER_BIT-1 (mid stop bit): rx_s==1 -> data<=shift reg,
//          valid=1 next cycle, -> IDLE; rx_s==0 -> frame_err=1 next cycle, -> BREAK.
// - BREAK: wait for rx_s==1, then IDLE (a held-low line yields exactly one frame_err).
// - valid/frame_err registered, high exactly one cycle, never simultaneously.
// - Latency: first clk edge sampling rx low = edge 0; START entered edge 2; mid-start check
//   edge 10 (for CLKS_PER_BIT=16); data bit k sampled edge 10+16*(k+1); stop sampled edge 154;
//   valid/frame_err high during the cycle after edge 154. General: stop sampled at
//   2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT.
// - Back-to-back frames: IDLE re-entered before end of stop bit, so a start bit immediately
//   after the stop bit is caught; no idle gap required.
// - Odd CLKS_PER_BIT: half point is floor(CLKS_PER_BIT/2)-1; no other change.
// STRUCTURE
// - Shared package serial_pkg: state enum (IDLE, START, DATA, STOP, BREAK), frame-format
//   constants (START_LVL=0, STOP_LVL=1, IDLE_LVL=1) reused by the future serial_tx.
// - Sub-module sync_2ff (2-flop synchronizer, async reset to parameter value 1); reusable.
// - Single always block for FSM + counters + shift reg; separate registered output pulses.
// TESTING (CLKS_PER_BIT=16, DATA_BITS=8 unless noted)
// - Frame 0xA5 (rx bits 0,1,0,1,0,0,1,0,1,1 each 16 clk) -> valid 1 cycle after edge 154,
//   data=8'hA5, frame_err never high, busy low again by end of stop bit.
// - Low glitch of 5 clk on idle line -> no valid, no frame_err, FSM back to IDLE by edge 10.
// - Frame 0x3C with stop bit 0, then line held low 100 clk, then high -> exactly one
//   frame_err, data keeps previous value, busy low after rx_s returns high.
// - Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three valid pulses, data in order.
// - arst pulsed during data bit 4 of 0x55, line then completes frame -> no pulse from
//   aborted frame; all outputs 0 during reset; next clean frame 0x12 -> data=8'h12.
// - CLKS_PER_BIT=5, DATA_BITS=7, frame 7'h41 -> valid with data=7'h41, stop at edge 44.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-link definitions: receiver FSM states, line levels and a width helper.
// The line levels are also the frame-format contract for the transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both stages reset to RESET_VAL so the output is defined from the first cycle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic arst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments so the second stage takes the first stage's pre-edge value.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_rx.sv
// UART-style receiver: start bit, DATA_BITS data bits LSB first, one stop bit.
// Each bit is sampled at its centre, timed from the mid-point of the start bit.
module serial_rx
    import serial_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W  = width_of(CLKS_PER_BIT);
    localparam int BITN_W = width_of(DATA_BITS);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BITN_W-1:0] BITN_LAST = BITN_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e              state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [BITN_W-1:0]      bitn_q,      bitn_d;
    logic [DATA_BITS-1:0]   shift_q,     shift_d;
    logic [DATA_BITS-1:0]   data_q,      data_d;
    logic                   valid_q,     valid_d;
    logic                   frame_err_q, frame_err_d;

    sync_2ff #(
        .RESET_VAL (IDLE_LVL)
    ) u_sync (
        .clk  (clk),
        .arst (arst),
        .d_i  (rx),
        .q_o  (rx_s)
    );

    // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitn_d      = bitn_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_s == START_LVL) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s == START_LVL) begin
                        state_d = DATA;
                        bitn_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so after DATA_BITS shifts it sits at bit 0.
                    shift_d = shift_q >> 1;
                    shift_d[DATA_BITS-1] = rx_s;
                    if (bitn_q == BITN_LAST) begin
                        state_d = STOP;
                    end else begin
                        bitn_d = bitn_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s == STOP_LVL) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                // A line held low reports one error, then waits for it to go idle.
                if (rx_s == STOP_LVL) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the shift register is reset too, so a frame cut short by reset leaves no stale bits behind.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bitn_q  <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bitn_q  <= bitn_d;
            shift_q <= shift_d;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: a timeline model predicts every output each cycle from the
// sampled line, plus literal expectations for latency, data and pulse counts.
module tb_serial_rx;

    localparam int C        = 16;
    localparam int D        = 8;
    localparam int MID      = C / 2;
    localparam int STOP_OFF = MID + C * (D + 1);
    localparam int C2       = 5;
    localparam int D2       = 7;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    logic rx   = 1'b1;
    logic rx2  = 1'b1;

    logic [D-1:0]  data;
    logic          valid, frame_err, busy;
    logic [D2-1:0] data2;
    logic          valid2, frame_err2, busy2;

    int n_checks = 0;
    int n_fail   = 0;
    int pos_cnt  = 0;
    int last_start_pos = 0;

    int n_valid = 0, n_ferr = 0, last_valid_pos = 0;
    int n_valid2 = 0, n_ferr2 = 0, last_valid2_pos = 0;
    logic [D-1:0] got_q[$];

    // Model state: the line as the receiver sees it, and frame timing as edge offsets.
    logic         m_d1 = 1'b1, m_d2 = 1'b1, m_rs = 1'b1;
    logic         m_busy = 1'b0, m_brk = 1'b0;
    int           m_cyc = 0, m_start = 0, m_off = 0;
    logic [D-1:0] m_word = '0;
    logic [D-1:0] exp_data = '0;
    logic         exp_valid = 1'b0, exp_ferr = 1'b0;
    int           m_nvalid = 0, m_nferr = 0;

    serial_rx #(.DATA_BITS(D), .CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .arst      (arst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    serial_rx #(.DATA_BITS(D2), .CLKS_PER_BIT(C2)) dut2 (
        .clk       (clk),
        .arst      (arst),
        .rx        (rx2),
        .data      (data2),
        .valid     (valid2),
        .frame_err (frame_err2),
        .busy      (busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pos_cnt <= pos_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: start seen at edge s; start re-check at s+C/2; bit k at s+C/2+C*(k+1);
    // stop at s+C/2+C*(D+1). The receiver sees rx two edges late.
    initial forever begin
        @(posedge clk or posedge arst);
        if (arst) begin
            m_d1 = 1'b1; m_d2 = 1'b1;
            m_busy = 1'b0; m_brk = 1'b0;
            exp_data = '0; exp_valid = 1'b0; exp_ferr = 1'b0;
        end else begin
            m_cyc++;
            m_rs = m_d2; m_d2 = m_d1; m_d1 = rx;
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            if (m_brk) begin
                if (m_rs) m_brk = 1'b0;
            end else if (!m_busy) begin
                if (!m_rs) begin
                    m_busy  = 1'b1;
                    m_start = m_cyc;
                end
            end else begin
                m_off = m_cyc - m_start;
                if (m_off == MID) begin
                    if (m_rs) m_busy = 1'b0;
                end else if (m_off == STOP_OFF) begin
                    m_busy = 1'b0;
                    if (m_rs) begin
                        exp_data  = m_word;
                        exp_valid = 1'b1;
                        m_nvalid++;
                    end else begin
                        exp_ferr = 1'b1;
                        m_brk    = 1'b1;
                        m_nferr++;
                    end
                end else if (m_off > MID && (m_off - MID) % C == 0) begin
                    m_word[(m_off - MID) / C - 1] = m_rs;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("valid",     32'(valid),     32'(exp_valid));
        check("frame_err", 32'(frame_err), 32'(exp_ferr));
        check("data",      32'(data),      32'(exp_data));
        check("busy",      32'(busy),      32'(m_busy | m_brk));
        if (valid) begin
            n_valid++;
            last_valid_pos = pos_cnt;
            got_q.push_back(data);
        end
        if (frame_err) n_ferr++;
        if (valid2) begin
            n_valid2++;
            last_valid2_pos = pos_cnt;
        end
        if (frame_err2) n_ferr2++;
    end

    task automatic drive(input int which, input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) last_start_pos = pos_cnt;
            if (which == 0) rx = v;
            else            rx2 = v;
        end
    endtask

    task automatic send(input int which, input logic [15:0] word, input int nbits,
                        input int cpb, input logic stop, output int t0);
        drive(which, 1'b0, cpb);
        t0 = last_start_pos;
        for (int k = 0; k < nbits; k++) drive(which, word[k], cpb);
        drive(which, stop, cpb);
    endtask

    initial begin
        int t0;
        int nv0, nf0, q0;
        logic [15:0] w55;
        logic [15:0] b2b [3];

        repeat (3) @(negedge clk);
        #1;
        check("rst_valid",     32'(valid),     32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_data",      32'(data),      32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        #1 arst = 1'b0;
        drive(0, 1'b1, 20);

        // Clean frame 0xA5
        nv0 = n_valid; nf0 = n_ferr;
        send(0, 16'h00A5, D, C, 1'b1, t0);
        drive(0, 1'b1, 24);
        #1;
        check("a5_count",   32'(n_valid - nv0),                32'd1);
        check("a5_latency", 32'(last_valid_pos - (t0 + 1)),    32'd154);
        check("a5_data",    32'(data),                         32'h0A5);
        check("a5_no_ferr", 32'(n_ferr - nf0),                 32'd0);
        check("a5_busy",    32'(busy),                         32'd0);

        // 5-clk low glitch
        nv0 = n_valid; nf0 = n_ferr;
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 30);
        #1;
        check("glitch_valid", 32'(n_valid - nv0), 32'd0);
        check("glitch_ferr",  32'(n_ferr - nf0),  32'd0);
        check("glitch_busy",  32'(busy),          32'd0);

        // 0x3C with a bad stop bit, line then held low
        nv0 = n_valid; nf0 = n_ferr;
        send(0, 16'h003C, D, C, 1'b0, t0);
        drive(0, 1'b0, 100);
        drive(0, 1'b1, 20);
        #1;
        check("break_ferr",  32'(n_ferr - nf0),  32'd1);
        check("break_valid", 32'(n_valid - nv0), 32'd0);
        check("break_data",  32'(data),          32'h0A5);
        check("break_busy",  32'(busy),          32'd0);

        // Back-to-back frames, no idle gap
        nv0 = n_valid; q0 = got_q.size();
        b2b[0] = 16'h0000; b2b[1] = 16'h00FF; b2b[2] = 16'h0081;
        for (int i = 0; i < 3; i++) send(0, b2b[i], D, C, 1'b1, t0);
        drive(0, 1'b1, 30);
        #1;
        check("b2b_count", 32'(n_valid - nv0), 32'd3);
        if (got_q.size() >= q0 + 3) begin
            for (int i = 0; i < 3; i++) check("b2b_data", 32'(got_q[q0 + i]), 32'(b2b[i][D-1:0]));
        end

        // Reset in the middle of data bit 4 of 0x55
        w55 = 16'h0055;
        drive(0, 1'b0, C);
        for (int k = 0; k < 4; k++) drive(0, w55[k], C);
        drive(0, w55[4], 8);
        #2 arst = 1'b1;
        nv0 = n_valid; nf0 = n_ferr;
        drive(0, w55[4], 4);
        #1;
        check("arst_valid",     32'(valid),     32'd0);
        check("arst_frame_err", 32'(frame_err), 32'd0);
        check("arst_data",      32'(data),      32'd0);
        check("arst_busy",      32'(busy),      32'd0);
        #1 arst = 1'b0;
        check("arst_no_pulse", 32'((n_valid - nv0) + (n_ferr - nf0)), 32'd0);
        drive(0, w55[4], 4);
        for (int k = 5; k < D; k++) drive(0, w55[k], C);
        drive(0, 1'b1, C);
        drive(0, 1'b1, 200);
        send(0, 16'h0012, D, C, 1'b1, t0);
        drive(0, 1'b1, 30);
        #1;
        check("after_arst_data", 32'(data), 32'h012);

        // Randomized traffic: good frames, bad stops with held-low lines, short glitches
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                drive(0, 1'b0, $urandom_range(1, 6));
                drive(0, 1'b1, $urandom_range(1, 20));
            end else begin
                send(0, 16'($urandom_range(0, 255)), D, C, (kind != 1), t0);
                if (kind == 1) drive(0, 1'b0, $urandom_range(0, 30));
                drive(0, 1'b1, $urandom_range(0, 20));
            end
        end
        drive(0, 1'b1, 300);
        #1;
        check("rand_valid_count", 32'(n_valid), 32'(m_nvalid));
        check("rand_ferr_count",  32'(n_ferr),  32'(m_nferr));

        // Odd bit period and 7 data bits on the second instance
        send(1, 16'h0041, D2, C2, 1'b1, t0);
        drive(1, 1'b1, 20);
        #1;
        check("c5_count",   32'(n_valid2),                      32'd1);
        check("c5_latency", 32'(last_valid2_pos - (t0 + 1)),    32'd44);
        check("c5_data",    32'(data2),                         32'h41);
        check("c5_ferr",    32'(n_ferr2),                       32'd0);
        check("c5_busy",    32'(busy2),                         32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
